// File: rtl/pipe_register_q_bit_pkg.sv
// rtl/pipe_register_q_bit_pkg.sv - shared sizing helpers for the valid-qualified pipe register
package pipe_register_q_bit_pkg;

  localparam int DEFAULT_Q = 3;
  localparam int DEFAULT_D = 4;

  // Width needed to hold an occupancy count of 0..depth inclusive.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_register_q_bit_if.sv
// rtl/pipe_register_q_bit_if.sv - data/control bundle between a producer and the pipe register
interface pipe_register_q_bit_if
  import pipe_register_q_bit_pkg::*;
#(
  parameter int Q = DEFAULT_Q,
  parameter int D = DEFAULT_D
);

  localparam int CW = count_width(D);

  logic          en;
  logic          clr;
  logic          in_valid;
  logic [Q-1:0]  in;
  logic [Q-1:0]  out;
  logic          out_valid;
  logic [CW-1:0] count;
  logic          full;

  modport master (
    output en, clr, in_valid, in,
    input  out, out_valid, count, full
  );

  modport slave (
    input  en, clr, in_valid, in,
    output out, out_valid, count, full
  );

endinterface

// File: rtl/pipe_stage_q_bit.sv
// rtl/pipe_stage_q_bit.sv - one Q-bit data register with valid bit, enable and synchronous flush
module pipe_stage_q_bit #(
  parameter int Q = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic         d_valid,
  input  logic [Q-1:0] d,
  output logic         q_valid,
  output logic [Q-1:0] q
);

  // Data shifts even when d_valid is 0 so bubbles travel with the stream.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_valid <= 1'b0;
      q       <= '0;
    end else if (clr) begin
      q_valid <= 1'b0;
      q       <= '0;
    end else if (en) begin
      q_valid <= d_valid;
      q       <= d;
    end
  end

endmodule

// File: rtl/pipe_register_q_bit.sv
// rtl/pipe_register_q_bit.sv - D-stage valid-qualified pipe register with occupancy count and full flag
module pipe_register_q_bit
  import pipe_register_q_bit_pkg::*;
#(
  parameter int Q = DEFAULT_Q,
  parameter int D = DEFAULT_D
) (
  input  logic                  clk,
  input  logic                  rst,
  pipe_register_q_bit_if.slave  bus
);

  localparam int CW = count_width(D);

  // Index 0 is the input side; index k+1 is the output of stage k.
  logic [D:0][Q-1:0] data;
  logic [D:0]        valid;
  logic [CW-1:0]     count_q;

  assign data[0]  = bus.in;
  assign valid[0] = bus.in_valid;

  genvar k;
  generate
    for (k = 0; k < D; k++) begin : g_stage
      pipe_stage_q_bit #(.Q(Q)) u_stage (
        .clk     (clk),
        .rst     (rst),
        .en      (bus.en),
        .clr     (bus.clr),
        .d_valid (valid[k]),
        .d       (data[k]),
        .q_valid (valid[k+1]),
        .q       (data[k+1])
      );
    end
  endgenerate

  // Entering and leaving valid words on the same edge cancel, so count never overshoots.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else if (bus.clr) begin
      count_q <= '0;
    end else if (bus.en) begin
      if (bus.in_valid && !valid[D]) begin
        count_q <= count_q + CW'(1);
      end else if (!bus.in_valid && valid[D]) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

  assign bus.count     = count_q;
  assign bus.full      = (count_q == CW'(D));
  assign bus.out_valid = valid[D];
  assign bus.out       = valid[D] ? data[D] : '0;

endmodule

// File: doc/pipe_register_q_bit.md
PIPE_REGISTER_Q_BIT -- requirements
Module: pipe_register_q_bit

Interface
REQ-001 SHALL have parameter Q, default 3: data width in bits, Q >= 1.
REQ-002 SHALL have parameter D, default 4: number of pipeline stages, D >= 1.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port en, input, 1: shift enable; 0 means all stages hold.
REQ-006 SHALL have port clr, input, 1: synchronous flush of all stages.
REQ-007 SHALL have port in_valid, input, 1: qualifies in.
REQ-008 SHALL have port in, input, Q: data entering stage 0.
REQ-009 SHALL have port out, output, Q: data of stage D-1, gated.
REQ-010 SHALL have port out_valid, output, 1: valid bit of stage D-1.
REQ-011 SHALL have port count, output, CW = clog2(D+1): number of valid stages, 0..D.
REQ-012 SHALL have port full, output, 1: high when count == D.

Function
REQ-013 SHALL, on a rising edge with clr=0 and en=1, load {in_valid, in} into stage 0 and move stage k-1 into stage k for k = 1..D-1.
REQ-014 SHALL, on a rising edge with clr=0 and en=0, hold all stage data, valid bits and count.
REQ-015 SHALL, on a rising edge with clr=1, zero all stage data, valid bits and count, regardless of en or in_valid; clr has priority over en.
REQ-016 SHALL present data at out exactly D enabled edges after it was sampled at in; latency counts enabled edges only.
REQ-017 SHALL drive out = stage D-1 data when out_valid=1, and out = 0 when out_valid=0.
REQ-018 SHALL shift stage data even when the entering valid bit is 0, so bubbles propagate.
REQ-019 SHALL update count on an enabled edge as count + in_valid - valid[D-1], in one edge, with no intermediate value.
REQ-020 SHALL keep count unchanged when in_valid=1 and valid[D-1]=1 on the same enabled edge, including when full=1.
REQ-021 SHALL never let count exceed D or go below 0.
REQ-022 SHALL make full and out_valid register-derived, with no combinational path from in, in_valid, en or clr.
REQ-023 SHALL, with D=1, behave as a single Q-bit register with valid, latency 1.

Reset
REQ-024 SHALL, while rst=0, immediately force all stage data to 0, all valid bits to 0, count to 0, out to 0, out_valid to 0 and full to 0, without waiting for clk.
REQ-025 SHALL, when rst is asserted mid-stream, lose all in-flight data.
REQ-026 SHALL, when rst deasserts, apply the first update on the next rising edge; stimulus changes only away from rising edges.

Structure
REQ-027 SHALL place the count-width computation (clog2 of D+1) in the shared package or include used by the MAC blocks.
REQ-028 SHALL implement one sub-module, pipe_stage_q_bit, instantiated D times via generate: a Q-bit data register plus valid bit with clk, rst, en and clr.
REQ-029 SHALL keep count and full logic in the top module.

Verification (Q=3, D=4)
REQ-030 SHALL verify reset: rst=0 for one cycle with in=2 and in_valid=1 -> out=000, out_valid=0, count=0 throughout; first update on the first edge after release.
REQ-031 SHALL verify streaming: en=1, in_valid=1, in=2,1,6,7 on consecutive edges -> out=010,001,110,111 on edges 4..7, count rises 1,2,3,4, full=1 at edge 4.
REQ-032 SHALL verify stall: en=0 for 2 cycles mid-stream -> out, out_valid and count frozen; sequence resumes with latency extended by 2.
REQ-033 SHALL verify bubbles: in_valid pattern 1,0,1,0 -> out_valid 1,0,1,0 at edges 4..7; out=000 while out_valid=0; count never exceeds 2.
REQ-034 SHALL verify flush: clr=1 for one edge with count=4 and en=1 -> count=0, out_valid=0 next cycle; in sampled on that edge is discarded.
REQ-035 SHALL verify full steady state: in_valid=1 held with full=1 -> count stays 4, one word in and one word out per edge.
